// File: rtl/spart_drv_pkg.sv
// Shared types and constants for the SPART echo driver.
// Contents:
//   drv_state_t  - driver FSM states
//   ADDR_*       - SPART register addresses on ioaddr
//   bus_op_t     - one registered bus cycle (chip select, direction, address, write data)
//   baud_div()   - 16-bit divisor for a 2-bit baud select at 25 MHz
package spart_drv_pkg;

  typedef enum logic [2:0] {
    CFG_LO  = 3'd0,
    CFG_HI  = 3'd1,
    IDLE    = 3'd2,
    READ    = 3'd3,
    WRITE   = 3'd4,
    TX_HOLD = 3'd5
  } drv_state_t;

  localparam logic [1:0] ADDR_BUF   = 2'b00;
  localparam logic [1:0] ADDR_STAT  = 2'b01;
  localparam logic [1:0] ADDR_DB_LO = 2'b10;
  localparam logic [1:0] ADDR_DB_HI = 2'b11;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;

  typedef struct packed {
    logic              cs;
    logic              rw;
    logic [1:0]        addr;
    logic [DATA_W-1:0] data;
  } bus_op_t;

  localparam bus_op_t BUS_IDLE = '{cs: 1'b0, rw: 1'b1, addr: ADDR_BUF, data: 8'h00};

  // Divisor = round(25e6 / (16 * baud)) - 1
  function automatic logic [DIV_W-1:0] baud_div(input logic [1:0] sel);
    logic [DIV_W-1:0] div;
    case (sel)
      2'b00:   div = 16'h0145;  // 4800
      2'b01:   div = 16'h00A2;  // 9600
      2'b10:   div = 16'h0050;  // 19200
      default: div = 16'h0028;  // 38400
    endcase
    return div;
  endfunction

  function automatic bus_op_t bus_wr(input logic [1:0] addr, input logic [DATA_W-1:0] data);
    bus_op_t op;
    op.cs   = 1'b1;
    op.rw   = 1'b0;
    op.addr = addr;
    op.data = data;
    return op;
  endfunction

  function automatic bus_op_t bus_rd(input logic [1:0] addr);
    bus_op_t op;
    op.cs   = 1'b1;
    op.rw   = 1'b1;
    op.addr = addr;
    op.data = 8'h00;
    return op;
  endfunction

endpackage

// File: rtl/spart_driver_if.sv
// Processor-side SPART control bus (the 8-bit databus stays a plain inout port).
//   iocs   - chip select            (master -> SPART)
//   iorw   - 1=read, 0=write        (master -> SPART)
//   ioaddr - register address       (master -> SPART)
//   rda    - receive data available (SPART -> master)
//   tbr    - transmit buffer ready  (SPART -> master)
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_driver_echo_fifo.sv
// echo_fifo: small synchronous FIFO with first-word-fall-through head.
//   clk, rst  - clock, synchronous active-high reset (flushes pointers)
//   push_i    - write din_i (ignored when full)
//   pop_i     - drop the head entry (ignored when empty)
//   din_i     - write data
//   dout_o    - current head entry, valid while !empty_o
//   full_o    - DEPTH entries held
//   empty_o   - no entries held
//   count_o   - occupancy 0..DEPTH
module echo_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // Pointers wrap naturally at DEPTH (power of two); count tells full from empty
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/spart_driver.sv
// spart_driver: bus master that programs the SPART baud divisor from br_cfg and
// then echoes every received byte back through a small FIFO.
//   clk, rst    - 25 MHz clock, synchronous active-high reset
//   br_cfg      - baud select (00=4800, 01=9600, 10=19200, 11=38400)
//   bus         - spart_driver_if.master: iocs/iorw/ioaddr out, rda/tbr in
//   databus     - shared 8-bit bus, driven only during write cycles
//   cfg_done    - divisor programmed for the current br_cfg
//   fifo_count  - echo FIFO occupancy
// Build option: define SPART_DRV_UPCASE_EN to store received 'a'..'z' as 'A'..'Z'.
module spart_driver
  import spart_drv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  spart_driver_if.master                bus,
  inout  wire  [7:0]                    databus,
  output logic                          cfg_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  drv_state_t        state_q, state_d;
  bus_op_t           op_q, op_d;
  logic [1:0]        cfg_q, cfg_d;
  logic              cfg_done_q, cfg_done_d;

  logic [DIV_W-1:0]  div_new;
  logic [DIV_W-1:0]  div_cur;
  logic [DATA_W-1:0] rx_byte;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic              push, pop;

  assign div_new = baud_div(br_cfg);
  assign div_cur = baud_div(cfg_q);

  // Byte captured from the bus at the end of a READ cycle
`ifdef SPART_DRV_UPCASE_EN
  always_comb begin
    rx_byte = databus;
    if (databus >= 8'h61 && databus <= 8'h7A) rx_byte = databus - 8'h20;
  end
`else
  assign rx_byte = databus;
`endif

  // The operation on the bus this cycle completes at the next edge
  assign push = (state_q == READ);
  assign pop  = (state_q == WRITE);

  echo_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (rx_byte),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next state plus the bus cycle that state drives (registered into op_q)
  always_comb begin
    state_d    = state_q;
    op_d       = BUS_IDLE;
    cfg_d      = cfg_q;
    cfg_done_d = cfg_done_q;

    case (state_q)
      CFG_LO: begin
        // Out of reset the bus is still idle here, so issue the low write now
        if (op_q.cs) begin
          state_d = CFG_HI;
          op_d    = bus_wr(ADDR_DB_HI, div_cur[15:8]);
        end else begin
          cfg_d = br_cfg;
          op_d  = bus_wr(ADDR_DB_LO, div_new[7:0]);
        end
      end
      CFG_HI: begin
        state_d    = IDLE;
        cfg_done_d = 1'b1;
      end
      IDLE: begin
        if (br_cfg != cfg_q) begin
          state_d    = CFG_LO;
          cfg_done_d = 1'b0;
          cfg_d      = br_cfg;
          op_d       = bus_wr(ADDR_DB_LO, div_new[7:0]);
        end else if (bus.rda && !fifo_full) begin
          state_d = READ;
          op_d    = bus_rd(ADDR_BUF);
        end else if (!fifo_empty && bus.tbr) begin
          state_d = WRITE;
          op_d    = bus_wr(ADDR_BUF, fifo_head);
        end
      end
      READ:    state_d = IDLE;
      WRITE:   state_d = TX_HOLD;
      // tbr is ignored here so the SPART has a cycle to drop it
      TX_HOLD: state_d = IDLE;
      default: state_d = CFG_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CFG_LO;
      op_q       <= BUS_IDLE;
      cfg_q      <= 2'b00;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cfg_q      <= cfg_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  assign bus.iocs   = op_q.cs;
  assign bus.iorw   = op_q.rw;
  assign bus.ioaddr = op_q.addr;
  assign databus    = (op_q.cs && !op_q.rw) ? op_q.data : 8'hzz;
  assign cfg_done   = cfg_done_q;

endmodule
